// File: rtl/radix4_divider.sv
// Iterative radix-4 restoring divider, signed/unsigned; 19-cycle latency (1 for divide-by-zero).
// Backpressure: result held in DONE until out_ready; in_ready only while idle, no overlap.
module radix4_divider #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             is_signed,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);
   localparam int STEPS = WIDTH / 2;
   localparam int CW    = $clog2(STEPS);

   typedef enum logic [2:0] {IDLE, PREP, ITER, FIX, DONE} state_t;

   state_t           state;
   logic [WIDTH-1:0] a_reg, b_reg, mag, q_reg;
   logic             sgn, neg_q, neg_r;
   logic [WIDTH+1:0] d1, d2, d3, r;
   logic [CW-1:0]    cnt;

   logic [WIDTH-1:0] a_abs, b_abs;
   logic [WIDTH+1:0] r_sh, r_next;
   logic [1:0]       q_dig;

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);

   // Partial remainder stays below d, so the shifted value always fits WIDTH+2 bits.
   always_comb begin
      a_abs  = (sgn && a_reg[WIDTH-1]) ? -a_reg : a_reg;
      b_abs  = (sgn && b_reg[WIDTH-1]) ? -b_reg : b_reg;
      r_sh   = (r << 2) | {{WIDTH{1'b0}}, mag[WIDTH-1:WIDTH-2]};
      q_dig  = 2'd0;
      r_next = r_sh;
      if (r_sh >= d3) begin
         q_dig  = 2'd3;
         r_next = r_sh - d3;
      end else if (r_sh >= d2) begin
         q_dig  = 2'd2;
         r_next = r_sh - d2;
      end else if (r_sh >= d1) begin
         q_dig  = 2'd1;
         r_next = r_sh - d1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         a_reg       <= '0;
         b_reg       <= '0;
         sgn         <= 1'b0;
         neg_q       <= 1'b0;
         neg_r       <= 1'b0;
         d1          <= '0;
         d2          <= '0;
         d3          <= '0;
         r           <= '0;
         mag         <= '0;
         q_reg       <= '0;
         cnt         <= '0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  a_reg <= dividend;
                  b_reg <= divisor;
                  sgn   <= is_signed;
                  if (divisor == '0) begin
                     quotient    <= '1;
                     remainder   <= dividend;
                     div_by_zero <= 1'b1;
                     state       <= DONE;
                  end else begin
                     div_by_zero <= 1'b0;
                     state       <= PREP;
                  end
               end
            end
            PREP: begin
               neg_q <= sgn & (a_reg[WIDTH-1] ^ b_reg[WIDTH-1]);
               neg_r <= sgn & a_reg[WIDTH-1];
               d1    <= {2'b00, b_abs};
               d2    <= {1'b0, b_abs, 1'b0};
               d3    <= {2'b00, b_abs} + {1'b0, b_abs, 1'b0};
               r     <= '0;
               mag   <= a_abs;
               q_reg <= '0;
               cnt   <= '0;
               state <= ITER;
            end
            ITER: begin
               r     <= r_next;
               mag   <= mag << 2;
               q_reg <= {q_reg[WIDTH-3:0], q_dig};
               cnt   <= cnt + CW'(1);
               if (cnt == CW'(STEPS - 1))
                  state <= FIX;
            end
            FIX: begin
               quotient  <= neg_q ? -q_reg : q_reg;
               remainder <= neg_r ? -r[WIDTH-1:0] : r[WIDTH-1:0];
               state     <= DONE;
            end
            DONE: begin
               if (out_ready)
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: doc/radix4_divider.md
# radix4_divider

Iterative 32-bit radix-4 restoring integer divider; the inverse arithmetic unit of the combinational Booth multiplier. It retires two quotient bits per cycle, so it takes 16 iteration steps, matching the multiplier's 16 radix-4 partial-product groups. It sits beside the multiplier in the execute datapath and supports signed and unsigned operation. Its results follow RISC-V M-extension semantics for the divide-by-zero and overflow corner cases.

## Interface
- WIDTH, 32: operand width; must be even; all arithmetic below is stated for WIDTH=32.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operands valid.
- in_ready  output  1  divider idle and able to accept operands.
- is_signed  input  1  1 = two's-complement operands, 0 = unsigned; sampled at acceptance.
- dividend  input  WIDTH  numerator; sampled at acceptance.
- divisor  input  WIDTH  denominator; sampled at acceptance.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- quotient  output  WIDTH  quotient, registered.
- remainder  output  WIDTH  remainder, registered.
- div_by_zero  output  1  divisor was zero; registered, valid with out_valid.

## Operation
- States: IDLE, PREP, ITER, FIX, DONE. in_ready = (state==IDLE).
- IDLE: input handshake (in_valid & in_ready) latches the operands and is_signed.
  - If divisor==0, go to DONE.
  - Otherwise go to PREP.
- PREP:
  - Take absolute values when is_signed; |0x80000000| = 0x80000000 as an unsigned magnitude.
  - Record neg_q = sign(dividend) XOR sign(divisor) and neg_r = sign(dividend), both only when is_signed.
  - Precompute d, 2d, 3d as WIDTH+2-bit values.
  - Clear the partial remainder r (WIDTH+2 bits) and load the magnitude shift register.
  - Reset the step counter to 0.
- ITER: one step per cycle, 16 steps.
  - r' = {r, next 2 MSBs of the dividend magnitude}.
  - q = largest of {3,2,1,0} with q·d ≤ r'.
  - r = r' − q·d.
  - Shift q into the quotient register.
  - Counter increments; leave ITER after step 15.
- FIX:
  - quotient = neg_q ? −Q : Q.
  - remainder = neg_r ? −R : R (low WIDTH bits).
  - Go to DONE.
- DONE: out_valid=1; hold all outputs stable until out_ready=1, then go to IDLE.
- Divide by zero, direct path from IDLE: quotient = all ones, remainder = dividend unmodified, div_by_zero = 1. This applies to both signed and unsigned.
- Signed overflow (0x80000000 / 0xFFFFFFFF): falls out of the normal path, giving quotient = 0x80000000, remainder = 0, div_by_zero = 0. No special casing.
- Invariant for all non-zero divisors: quotient·divisor + remainder == dividend (mod 2^WIDTH). The remainder takes the dividend's sign and has |remainder| < |divisor|.

## Timing
- Reset (asynchronous, takes effect immediately):
  - State goes to IDLE; in_ready=1 and out_valid=0.
  - quotient, remainder and div_by_zero go to 0.
  - Internal r, step counter and sign flags are cleared.
- Normal latency: handshake on edge T; PREP in cycle T+1, ITER in T+2..T+17, FIX in T+18. out_valid is high from the cycle after edge T+18, which is 19 cycles after acceptance.
- Divide-by-zero latency: out_valid is high 1 cycle after acceptance.
- in_ready is low from the cycle after acceptance until the cycle after the output handshake. There is no overlap, so the minimum initiation interval is 20 cycles (2 for divide-by-zero).
- With out_valid & out_ready in the same cycle, the result is consumed at that edge. in_ready rises the next cycle.
- in_valid while busy is ignored; the operands are not captured.
- Reset asserted mid-ITER or mid-DONE aborts the operation; the result is lost and no out_valid is produced.
- Operands may change freely after acceptance without affecting the result.

## Test plan
- Unsigned 100/7 -> quotient=14, remainder=2, div_by_zero=0, out_valid exactly 19 cycles after acceptance.
- Signed −7/2 (0xFFFFFFF9, 0x00000002) -> quotient=0xFFFFFFFD, remainder=0xFFFFFFFF. Also check 7/−2 -> quotient=0xFFFFFFFD, remainder=1.
- Signed and unsigned 5/0 -> quotient=0xFFFFFFFF, remainder=5, div_by_zero=1, out_valid 1 cycle after acceptance.
- Signed 0x80000000/0xFFFFFFFF -> quotient=0x80000000, remainder=0. Also check unsigned 0xFFFFFFFF/1 -> quotient=0xFFFFFFFF, remainder=0.
- Backpressure:
  - Hold out_ready=0 for 5 cycles in DONE; outputs must stay stable and in_ready must stay 0.
  - Pulse in_valid with new operands during ITER; they must be ignored.
- Reset at ITER step 8 -> out_valid=0 and in_ready=1 immediately. A following 1000/3 must give quotient=333, remainder=1. Then run 10k random signed/unsigned pairs checked against the invariant and a reference model.
